spi_byte_sequencer: RTL and testbench



---
 rtl/spi_byte_sequencer.sv | 119 +++++++++++
 tb/tb_spi_byte_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_sequencer.sv
// Host-side front end for the SPI byte master: TX FIFO -> one start per byte,
// received bytes collected in an RX FIFO with first-word fall-through.
module spi_byte_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             flush,
  input  logic             tx_valid,
  input  logic [7:0]       tx_byte,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_byte,
  input  logic             rx_ready,
  output logic [LVL_W-1:0] tx_level,
  output logic [LVL_W-1:0] rx_level,
  output logic             idle,
  output logic [15:0]      xfer_count,
  output logic             master_start,
  output logic [7:0]       master_tx_data,
  input  logic             master_busy,
  input  logic             master_done,
  input  logic [7:0]       master_rx_data
);

  // state     | meaning
  // IDLE      | no transfer in flight, waiting for a byte and RX space
  // ISSUE     | start pulse high for this one cycle
  // WAIT_BUSY | waiting for the master to report busy
  // WAIT_DONE | waiting for the master's done pulse
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);

  state_t           state;
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic             flush_seen;
  logic             tx_push, rx_pop, rx_push, issue, done_acc;

  assign tx_ready = (tx_level != FULL) && !flush;
  assign tx_push  = tx_valid && tx_ready;
  assign rx_valid = (rx_level != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_byte  = rx_mem[rx_rd_ptr];
  assign idle     = (state == IDLE) && (tx_level == '0);

  assign issue    = (state == IDLE) && enable && (tx_level != '0) &&
                    (rx_level != FULL) && !master_busy && !flush;
  assign done_acc = ((state == WAIT_BUSY) || (state == WAIT_DONE)) && master_done;
  // A flush anywhere inside the transfer discards its received byte.
  assign rx_push  = done_acc && !flush && !flush_seen;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_byte;
    if (rx_push) rx_mem[rx_wr_ptr] <= master_rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else if (flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (issue)   tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_level <= tx_level + LVL_W'(tx_push) - LVL_W'(issue);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_level <= rx_level + LVL_W'(rx_push) - LVL_W'(rx_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      master_start   <= 1'b0;
      master_tx_data <= '0;
      xfer_count     <= '0;
      flush_seen     <= 1'b0;
    end else begin
      master_start <= 1'b0;
      if (done_acc) xfer_count <= xfer_count + 16'd1;
      if (issue) flush_seen <= 1'b0;
      else if (flush && (state != IDLE)) flush_seen <= 1'b1;
      case (state)
        IDLE: begin
          if (issue) begin
            state          <= ISSUE;
            master_start   <= 1'b1;
            master_tx_data <= tx_mem[tx_rd_ptr];
          end
        end
        ISSUE: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (master_done)      state <= IDLE;
          else if (master_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: if (master_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a loopback SPI master model.
module tb_spi_byte_sequencer;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n, enable, flush, tx_valid, rx_ready;
  logic [7:0]    tx_byte;
  logic          tx_ready, rx_valid, idle, master_start;
  logic [7:0]    rx_byte, master_tx_data, master_rx_data;
  logic [LW-1:0] tx_level, rx_level;
  logic [15:0]   xfer_count;
  logic          master_busy, master_done;

  spi_byte_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level), .idle(idle),
    .xfer_count(xfer_count), .master_start(master_start),
    .master_tx_data(master_tx_data), .master_busy(master_busy),
    .master_done(master_done), .master_rx_data(master_rx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Master model: busy from the start cycle, done pulse echoing the sent byte.
  logic       m_active = 1'b0, m_hold = 1'b0, m_stall = 1'b0, m_stray = 1'b0;
  logic [7:0] m_data;
  int         m_cnt = 0, n_start = 0, n_bad = 0, start_cyc = 0;
  logic [7:0] start_q[$];

  initial begin
    master_busy = 1'b0; master_done = 1'b0; master_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_active = 1'b0; master_busy = 1'b0; master_done = 1'b0;
      end else begin
        master_done = 1'b0;
        if (m_stray) begin
          master_done = 1'b1; master_rx_data = 8'hEE; m_stray = 1'b0;
        end else if (m_active && !m_stall && !m_hold) begin
          if (m_cnt == 0) begin
            master_done = 1'b1; master_busy = 1'b0;
            master_rx_data = m_data; m_active = 1'b0;
          end else m_cnt--;
        end
        if (master_start) begin
          n_start++;
          start_q.push_back(master_tx_data);
          start_cyc = cyc;
          if (m_active) n_bad++;
          m_active = 1'b1; m_data = master_tx_data; m_cnt = 2;
          if (!m_stall) master_busy = 1'b1;
        end
      end
    end
  end

  int push_cyc = 0, pop_cyc = 0;

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    tx_valid = 1'b1; tx_byte = b;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    push_cyc = cyc;
  endtask

  task automatic pop_rx(input logic [7:0] exp, input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_byte"}, 32'(rx_byte), 32'(exp));
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    pop_cyc = cyc;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (!idle && n < max);
    chk(tag, 32'(idle), 32'd1);
  endtask

  task automatic wait_starts(input int target, input int max, input string tag);
    int n = 0;
    while (n_start < target && n < max) begin @(negedge clk); #1; n++; end
    chk(tag, 32'(n_start >= target), 32'd1);
  endtask

  task automatic chk_start(input logic [7:0] exp, input string tag);
    if (start_q.size() == 0) chk({tag, "_none"}, 32'd0, 32'd1);
    else chk(tag, 32'(start_q.pop_front()), 32'(exp));
  endtask

  int base, exp_xfer;

  initial begin
    reset_n = 1'b0; enable = 1'b0; flush = 1'b0; tx_valid = 1'b0;
    tx_byte = 8'h00; rx_ready = 1'b0; exp_xfer = 0;
    #12;
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_levels", 32'({tx_level, rx_level}), 32'd0);
    chk("rst_xfer", 32'(xfer_count), 32'd0);
    chk("rst_start", 32'({master_start, master_tx_data}), 32'd0);
    @(negedge clk); reset_n = 1'b1; enable = 1'b1;

    // single byte loopback and issue latency
    push(8'hA5);
    wait_idle(50, "t1_idle");
    chk("t1_starts", 32'(n_start), 32'd1);
    chk("t1_latency", 32'(start_cyc - push_cyc), 32'd1);
    chk_start(8'hA5, "t1_start_data");
    chk("t1_rx_level", 32'(rx_level), 32'd1);
    chk("t1_xfer", 32'(xfer_count), 32'd1);
    chk("t1_tx_hold", 32'(master_tx_data), 32'hA5);
    pop_rx(8'hA5, "t1_pop");
    exp_xfer = 1;

    // fill TX with enable low, then burst eight bytes
    enable = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    @(negedge clk);
    chk("t2_tx_full_ready", 32'(tx_ready), 32'd0);
    chk("t2_tx_level", 32'(tx_level), 32'd8);
    enable = 1'b1;
    wait_idle(300, "t2_idle");
    chk("t2_starts", 32'(n_start), 32'd9);
    for (int i = 1; i <= 8; i++) chk_start(8'(i), "t2_order");
    chk("t2_rx_level", 32'(rx_level), 32'd8);
    exp_xfer += 8;
    chk("t2_xfer", 32'(xfer_count), 32'(exp_xfer));
    chk("t2_bad_start", 32'(n_bad), 32'd0);

    // RX full blocks issue; one pop frees it
    push(8'h55);
    repeat (10) @(negedge clk);
    #1;
    chk("t3_blocked", 32'(n_start), 32'd9);
    chk("t3_tx_level", 32'(tx_level), 32'd1);
    pop_rx(8'h01, "t3_pop");
    wait_starts(10, 4, "t3_issued");
    chk("t3_issue_lat", 32'(start_cyc - pop_cyc), 32'd1);
    chk_start(8'h55, "t3_start_data");
    wait_idle(50, "t3_idle");
    chk("t3_rx_level", 32'(rx_level), 32'd8);
    for (int i = 2; i <= 8; i++) pop_rx(8'(i), "t3_drain");
    pop_rx(8'h55, "t3_drain_last");
    exp_xfer += 1;

    // enable drops after the second start of a four-byte burst
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    base = n_start;
    enable = 1'b1;
    wait_starts(base + 2, 60, "t4_two_starts");
    enable = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("t4_paused_starts", 32'(n_start), 32'(base + 2));
    chk("t4_rx_level", 32'(rx_level), 32'd2);
    chk("t4_tx_level", 32'(tx_level), 32'd2);
    chk("t4_xfer", 32'(xfer_count), 32'(exp_xfer + 2));
    enable = 1'b1;
    wait_idle(100, "t4_idle");
    chk("t4_starts", 32'(n_start), 32'(base + 4));
    for (int i = 0; i < 4; i++) chk_start(8'h11 + 8'(i), "t4_order");
    for (int i = 0; i < 4; i++) pop_rx(8'h11 + 8'(i), "t4_drain");
    exp_xfer += 4;

    // flush while the master is mid-transfer
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    m_hold = 1'b1;
    base = n_start;
    enable = 1'b1;
    wait_starts(base + 1, 10, "t5_started");
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("t5_flush_ready", 32'(tx_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t5_levels", 32'({tx_level, rx_level}), 32'd0);
    m_hold = 1'b0;
    wait_idle(50, "t5_idle");
    repeat (2) @(negedge clk);
    chk("t5_rx_level", 32'(rx_level), 32'd0);
    chk("t5_rx_valid", 32'(rx_valid), 32'd0);
    exp_xfer += 1;
    chk("t5_xfer", 32'(xfer_count), 32'(exp_xfer));
    chk("t5_starts", 32'(n_start), 32'(base + 1));
    chk_start(8'h21, "t5_start_data");
    chk("t5_bad_start", 32'(n_bad), 32'd0);

    // reset while waiting for busy
    m_stall = 1'b1;
    base = n_start;
    push(8'h31);
    push(8'h32);
    wait_starts(base + 1, 10, "t6_started");
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_start", 32'(master_start), 32'd0);
    chk("t6_rst_levels", 32'({tx_level, rx_level}), 32'd0);
    chk("t6_rst_idle", 32'(idle), 32'd1);
    chk("t6_rst_xfer", 32'(xfer_count), 32'd0);
    repeat (2) @(negedge clk);
    m_stall = 1'b0;
    start_q.delete();
    reset_n = 1'b1;
    push(8'h3C);
    wait_idle(50, "t6_idle");
    chk_start(8'h3C, "t6_start_data");
    chk("t6_xfer", 32'(xfer_count), 32'd1);
    pop_rx(8'h3C, "t6_pop");

    // stray done in IDLE is ignored
    @(negedge clk); m_stray = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_rx_level", 32'(rx_level), 32'd0);
    chk("stray_xfer", 32'(xfer_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
